peripheral_mpram_tl_multiport: RTL and testbench

Multi-port TILELINK-style BIU slave with an integrated byte-enabled single-port RAM. CORES independent core-side BIU channels share one RAM through a round-robin arbiter. Supports single and fixed-length INCR/WRAP bursts, sized sub-word accesses, and error responses. Next-generation replacement for the single-port bridge-plus-generic-RAM pairing in the MPRAM peripheral.

---
 rtl/peripheral_biu_pkg.sv | 39 +++
 rtl/peripheral_mpram_pkg.sv | 11 +
 rtl/peripheral_mpram_arbiter_rr.sv | 32 +++
 rtl/peripheral_mpram_tl_multiport.sv | 221 ++++++++++++++++++++++
 tb/tb_peripheral_mpram_tl_multiport.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_biu_pkg.sv
// BIU burst-type and transfer-size constants plus burst geometry helpers.
package peripheral_biu_pkg;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } biu_type_t;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HWORD = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  // Number of beats in a burst; open-ended INCR is treated as a single beat.
  function automatic logic [4:0] beat_count(input logic [2:0] btype);
    case (btype)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

  function automatic logic is_wrap(input logic [2:0] btype);
    return (btype == WRAP4) || (btype == WRAP8) || (btype == WRAP16);
  endfunction

  // Byte mask of the aligned window a wrapping burst stays inside.
  function automatic logic [11:0] wrap_mask(input logic [4:0] beats, input logic [2:0] size);
    return ({7'd0, beats} << size) - 12'd1;
  endfunction

endpackage

// File: rtl/peripheral_mpram_pkg.sv
// Shared types for the multi-port MPRAM BIU slave.
package peripheral_mpram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    BEAT   = 2'd2,
    LOCKED = 2'd3
  } mpram_state_t;

endpackage

// File: rtl/peripheral_mpram_arbiter_rr.sv
// Round-robin request picker: first requester after the pointer wins.
module peripheral_mpram_arbiter_rr #(
  parameter int CORES = 2,
  parameter int PW    = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic [CORES-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [CORES-1:0] gnt_o,
  output logic [PW-1:0]    gnt_idx_o,
  output logic             vld_o
);

  logic [PW-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    vld_o     = 1'b0;
    idx       = '0;
    for (int i = CORES; i >= 1; i--) begin
      idx = PW'((int'(ptr_i) + i) % CORES);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_mpram_tl_multiport.sv
// Multi-port BIU slave sharing one byte-enabled RAM between CORES channels.
module peripheral_mpram_tl_multiport #(
  parameter int XLEN  = 64,
  parameter int PLEN  = 64,
  parameter int CORES = 2,
  parameter int DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CORES-1:0]        biu_stb_i,
  output logic [CORES-1:0]        biu_stb_ack_o,
  output logic [CORES-1:0]        biu_d_ack_o,
  input  logic [CORES*PLEN-1:0]   biu_adri_i,
  output logic [CORES*PLEN-1:0]   biu_adro_o,
  input  logic [CORES*3-1:0]      biu_size_i,
  input  logic [CORES*3-1:0]      biu_type_i,
  input  logic [CORES*3-1:0]      biu_prot_i,
  input  logic [CORES-1:0]        biu_lock_i,
  input  logic [CORES-1:0]        biu_we_i,
  input  logic [CORES*XLEN-1:0]   biu_d_i,
  output logic [CORES*XLEN-1:0]   biu_q_o,
  output logic [CORES-1:0]        biu_ack_o,
  output logic [CORES-1:0]        biu_err_o
);

  import peripheral_biu_pkg::*;
  import peripheral_mpram_pkg::*;

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int ABITS = OFFW + IDXW;
  localparam int PW    = (CORES > 1) ? $clog2(CORES) : 1;
  localparam logic [PLEN-1:0] RAM_BYTES = PLEN'(DEPTH * BYTES);

  mpram_state_t      state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [4:0]        beats_q, beats_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [CORES-1:0]  stb_ack_q, stb_ack_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              d_ack_q, d_ack_d;

  logic [PLEN-1:0]   adr_q, adro_q;
  logic [2:0]        size_q, type_q;
  logic              we_q, prot0_q;
  logic [XLEN-1:0]   rd_q;
  logic [XLEN-1:0]   ram_q [DEPTH];

  logic [PLEN-1:0]   sel_adr;
  logic [2:0]        sel_size, sel_type;
  logic              sel_we, sel_prot0, sel_stb, sel_lock;
  logic [XLEN-1:0]   sel_d;

  logic [CORES-1:0]  arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_vld;

  logic              beat_go, beat_err;
  logic              err_range, err_size, err_align, err_prot;
  logic [PLEN-1:0]   align_mask, adr_inc, adr_mask, adr_nxt;
  logic [BYTES-1:0]  be;
  logic [IDXW-1:0]   widx;
  logic              unused_prot;

  assign sel_adr   = biu_adri_i[int'(gnt_q)*PLEN +: PLEN];
  assign sel_size  = biu_size_i[int'(gnt_q)*3 +: 3];
  assign sel_type  = biu_type_i[int'(gnt_q)*3 +: 3];
  assign sel_prot0 = biu_prot_i[int'(gnt_q)*3];
  assign sel_we    = biu_we_i[gnt_q];
  assign sel_stb   = biu_stb_i[gnt_q];
  assign sel_lock  = biu_lock_i[gnt_q];
  assign sel_d     = biu_d_i[int'(gnt_q)*XLEN +: XLEN];
  assign unused_prot = ^biu_prot_i;

  peripheral_mpram_arbiter_rr #(
    .CORES (CORES),
    .PW    (PW)
  ) u_arb (
    .req_i     (biu_stb_i),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .vld_o     (arb_vld)
  );

  assign beat_go = (state_q == BEAT) && (cnt_q != beats_q) && sel_stb;
  assign widx    = adr_q[OFFW +: IDXW];

  // Per-beat error classification and byte-lane enables from the current beat address.
  always_comb begin
    align_mask = (PLEN'(1) << size_q) - PLEN'(1);
    err_range  = (adr_q >= RAM_BYTES);
    err_size   = (size_q > 3'(OFFW));
    err_align  = |(adr_q & align_mask);
    err_prot   = !prot0_q && (&adr_q[ABITS-1 -: 3]);
    beat_err   = err_range || err_size || err_align || err_prot;
    be = '0;
    for (int b = 0; b < BYTES; b++) begin
      if ((b >= int'(adr_q[OFFW-1:0])) && (b < int'(adr_q[OFFW-1:0]) + (1 << size_q))) be[b] = 1'b1;
    end
  end

  // Next beat address: wrap inside the burst window for WRAP types, else modulo RAM size.
  always_comb begin
    adr_inc = PLEN'(1) << size_q;
    if (is_wrap(type_q)) adr_mask = PLEN'(wrap_mask(beats_q, size_q));
    else                 adr_mask = RAM_BYTES - PLEN'(1);
    adr_nxt = (adr_q & ~adr_mask) | ((adr_q + adr_inc) & adr_mask);
  end

  // Transaction sequencing: arbitrate, acknowledge strobe, run beats, release or hold grant.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    beats_d   = beats_q;
    cnt_d     = cnt_q;
    stb_ack_d = '0;
    ack_d     = beat_go && !beat_err;
    err_d     = beat_go && beat_err;
    d_ack_d   = beat_go && we_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d     = arb_idx;
          stb_ack_d = arb_gnt;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        beats_d = beat_count(sel_type);
        cnt_d   = '0;
        state_d = BEAT;
      end
      BEAT: begin
        if (beat_go) begin
          cnt_d = cnt_q + 5'd1;
        end else if (cnt_q == beats_q) begin
          ptr_d   = gnt_q;
          state_d = sel_lock ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        if (sel_stb) begin
          stb_ack_d[gnt_q] = 1'b1;
          state_d          = GRANT;
        end else if (!sel_lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      beats_q   <= '0;
      cnt_q     <= '0;
      stb_ack_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      beats_q   <= beats_d;
      cnt_q     <= cnt_d;
      stb_ack_q <= stb_ack_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      d_ack_q   <= d_ack_d;
    end
  end

  // Request capture, beat address stepping and the RAM itself (no reset on data).
  always_ff @(posedge clk) begin
    if (state_q == GRANT) begin
      adr_q   <= sel_adr;
      size_q  <= sel_size;
      type_q  <= sel_type;
      we_q    <= sel_we;
      prot0_q <= sel_prot0;
    end else if (beat_go) begin
      adr_q  <= adr_nxt;
      adro_q <= adr_q;
      if (!beat_err) begin
        if (we_q) begin
          for (int b = 0; b < BYTES; b++) begin
            if (be[b]) ram_q[widx][b*8 +: 8] <= sel_d[b*8 +: 8];
          end
        end else begin
          rd_q <= ram_q[widx];
        end
      end
    end
  end

  // Route the registered responses to the granted channel only.
  always_comb begin
    biu_stb_ack_o = stb_ack_q;
    biu_d_ack_o   = '0;
    biu_ack_o     = '0;
    biu_err_o     = '0;
    biu_q_o       = '0;
    biu_adro_o    = '0;
    biu_d_ack_o[gnt_q] = d_ack_q;
    biu_ack_o[gnt_q]   = ack_q;
    biu_err_o[gnt_q]   = err_q;
    if (ack_q && !we_q) biu_q_o[int'(gnt_q)*XLEN +: XLEN] = rd_q;
    if (ack_q || err_q) biu_adro_o[int'(gnt_q)*PLEN +: PLEN] = adro_q;
  end

endmodule

// File: tb/tb_peripheral_mpram_tl_multiport.sv
// Directed bench for the multi-port MPRAM BIU slave.
module tb_peripheral_mpram_tl_multiport;

  localparam int XLEN  = 64;
  localparam int PLEN  = 64;
  localparam int CORES = 2;
  localparam int DEPTH = 256;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CORES-1:0]      stb, lock, we;
  logic [CORES*PLEN-1:0] adri;
  logic [CORES*3-1:0]    size, btype, prot;
  logic [CORES*XLEN-1:0] d;
  logic [CORES-1:0]      stb_ack_o, d_ack_o, ack_o, err_o;
  logic [CORES*PLEN-1:0] adro_o;
  logic [CORES*XLEN-1:0] q_o;

  peripheral_mpram_tl_multiport #(
    .XLEN(XLEN), .PLEN(PLEN), .CORES(CORES), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .biu_stb_i     (stb),
    .biu_stb_ack_o (stb_ack_o),
    .biu_d_ack_o   (d_ack_o),
    .biu_adri_i    (adri),
    .biu_adro_o    (adro_o),
    .biu_size_i    (size),
    .biu_type_i    (btype),
    .biu_prot_i    (prot),
    .biu_lock_i    (lock),
    .biu_we_i      (we),
    .biu_d_i       (d),
    .biu_q_o       (q_o),
    .biu_ack_o     (ack_o),
    .biu_err_o     (err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int gnt_log[$];
  int both_cnt = 0;

  always @(negedge clk) begin
    for (int c = 0; c < CORES; c++) if (stb_ack_o[c]) gnt_log.push_back(c);
    if ($countones(stb_ack_o) > 1) both_cnt++;
  end

  logic [63:0] r_q[16], r_adro[16], wdat[16];
  logic        r_ack[16], r_err[16];
  int          n_res, n_dack, late, gap_acks, other_nz, both_resp;

  // Drive one transaction on channel c and record every response seen.
  task automatic run_burst(input int c, input logic [63:0] a, input logic [2:0] sz,
                           input logic [2:0] ty, input logic w, input logic pr, input logic lk,
                           input int nb, input int gap_at, input int gap_len, input int abort_at);
    int  budget, issued, gl, oc;
    logic go, seen;
    oc = 1 - c;
    n_res = 0; n_dack = 0; late = 0; gap_acks = 0; other_nz = 0; both_resp = 0;
    adri[c*PLEN +: PLEN] = a;
    size[c*3 +: 3]       = sz;
    btype[c*3 +: 3]      = ty;
    prot[c*3 +: 3]       = {2'b00, pr};
    we[c]                = w;
    lock[c]              = lk;
    d[c*XLEN +: XLEN]    = wdat[0];
    stb[c]               = 1'b1;
    seen = 1'b0; budget = 0;
    while (!seen && budget < 200) begin
      @(negedge clk);
      budget++;
      if (stb_ack_o[c]) seen = 1'b1;
    end
    check_eq("grant_wait", 64'(seen), 64'd1);
    if (seen) begin
      @(negedge clk);
      issued = 0; gl = gap_len; budget = 0;
      while (issued < nb && budget < 200) begin
        if (issued == abort_at) break;
        go = !(issued == gap_at && gl > 0);
        if (!go) gl--;
        stb[c] = go;
        d[c*XLEN +: XLEN] = wdat[issued];
        @(negedge clk);
        budget++;
        if (ack_o[c] || err_o[c]) begin
          r_ack[n_res]  = ack_o[c];
          r_err[n_res]  = err_o[c];
          r_q[n_res]    = q_o[c*XLEN +: XLEN];
          r_adro[n_res] = adro_o[c*PLEN +: PLEN];
          if (ack_o[c] && err_o[c]) both_resp++;
          if (n_res < 15) n_res++;
          if (!go) gap_acks++;
        end else if (go) begin
          late++;
        end
        if (d_ack_o[c]) n_dack++;
        if (stb_ack_o[oc] || ack_o[oc] || err_o[oc] || d_ack_o[oc] ||
            (|q_o[oc*XLEN +: XLEN]) || (|adro_o[oc*PLEN +: PLEN])) other_nz++;
        if (go) issued++;
      end
    end
    stb[c] = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_stb_ack"}, 64'(stb_ack_o), 64'd0);
    check_eq({tag, "_ack_err"}, 64'({ack_o, err_o, d_ack_o}), 64'd0);
    check_eq({tag, "_q"},       64'(|q_o), 64'd0);
    check_eq({tag, "_adro"},    64'(|adro_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stb = '0; lock = '0; we = '0; adri = '0; size = '0; btype = '0; prot = '0; d = '0;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) wdat[k] = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous requests with pointer 0: channel 1 first, then channel 0.
    gnt_log.delete(); both_cnt = 0;
    adri[0 +: PLEN] = 64'h40; size[0 +: 3] = 3'd3; btype[0 +: 3] = 3'd0; prot[0 +: 3] = 3'd1;
    we[0] = 1'b0; lock[0] = 1'b0; stb[0] = 1'b1;
    wdat[0] = 64'hCAFEF00D12345678;
    run_burst(1, 64'h40, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("arb_ch1_write_ack", 64'(r_ack[0]), 64'd1);
    check_eq("arb_ch1_other_quiet", 64'(other_nz), 64'd0);
    run_burst(0, 64'h40, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("arb_ch0_read_q", r_q[0], 64'hCAFEF00D12345678);
    check_eq("arb_grant_count", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      check_eq("arb_first_grant", 64'(gnt_log[0]), 64'd1);
      check_eq("arb_second_grant", 64'(gnt_log[1]), 64'd0);
    end
    check_eq("arb_no_double_stb_ack", 64'(both_cnt), 64'd0);

    // INCR4 write of words 0..3, then WRAP4 read starting mid-window.
    for (int k = 0; k < 4; k++) wdat[k] = 64'h0123456789ABCD00 + 64'(k);
    run_burst(0, 64'h00, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 4, -1, 0, -1);
    check_eq("incr4_wr_acks", 64'(n_res), 64'd4);
    check_eq("incr4_wr_dacks", 64'(n_dack), 64'd4);
    run_burst(0, 64'h18, 3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 4, -1, 0, -1);
    check_eq("wrap4_acks", 64'(n_res), 64'd4);
    check_eq("wrap4_adro0", r_adro[0], 64'h18);
    check_eq("wrap4_adro1", r_adro[1], 64'h00);
    check_eq("wrap4_adro2", r_adro[2], 64'h08);
    check_eq("wrap4_adro3", r_adro[3], 64'h10);
    check_eq("wrap4_q0", r_q[0], 64'h0123456789ABCD03);
    check_eq("wrap4_q1", r_q[1], 64'h0123456789ABCD00);

    // Single dword write and read back at 0x10.
    wdat[0] = 64'h1122334455667788;
    run_burst(0, 64'h10, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("single_wr_ack", 64'(r_ack[0]), 64'd1);
    run_burst(0, 64'h10, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("single_rd_latency", 64'(late), 64'd0);
    check_eq("single_rd_q", r_q[0], 64'h1122334455667788);
    check_eq("single_rd_adro", r_adro[0], 64'h10);

    // Byte write into lane 3, then a misaligned half write that must error.
    wdat[0] = 64'hABABABABABABABAB;
    run_burst(0, 64'h13, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1, -1, 0, -1);
    run_burst(0, 64'h10, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("byte_wr_merge", r_q[0], 64'h11223344AB667788);
    wdat[0] = 64'hFFFFFFFFFFFFFFFF;
    run_burst(0, 64'h11, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("misalign_err", 64'({r_err[0], r_ack[0]}), 64'b10);
    run_burst(0, 64'h10, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("misalign_no_write", r_q[0], 64'h11223344AB667788);

    // Channel 1 INCR4 read with a 3-cycle strobe gap before beat 2.
    run_burst(1, 64'h00, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 4, 2, 3, -1);
    check_eq("gap_total_acks", 64'(n_res), 64'd4);
    check_eq("gap_no_ack", 64'(gap_acks), 64'd0);
    check_eq("gap_adro2", r_adro[2], 64'h10);
    check_eq("gap_adro3", r_adro[3], 64'h18);
    check_eq("gap_q2", r_q[2], 64'h11223344AB667788);
    check_eq("gap_q3", r_q[3], 64'h0123456789ABCD03);
    check_eq("gap_both_resp", 64'(both_resp), 64'd0);

    // Error corners and INCR wrap at the top of RAM.
    run_burst(0, 64'h800, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("range_err", 64'({r_err[0], r_ack[0]}), 64'b10);
    run_burst(0, 64'h700, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1, -1, 0, -1);
    check_eq("prot_err", 64'({r_err[0], r_ack[0]}), 64'b10);
    run_burst(0, 64'h6F8, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1, -1, 0, -1);
    check_eq("prot_below_ok", 64'({r_err[0], r_ack[0]}), 64'b01);
    run_burst(0, 64'h00, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("size_err", 64'({r_err[0], r_ack[0]}), 64'b10);
    run_burst(0, 64'h7F0, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 4, -1, 0, -1);
    check_eq("incr_wrap_adro2", r_adro[2], 64'h00);
    check_eq("incr_wrap_q3", r_q[3], 64'h0123456789ABCD01);

    // Reset in the middle of an INCR8 write.
    for (int k = 0; k < 8; k++) wdat[k] = 64'h5000000000000000 + 64'(k);
    run_burst(0, 64'h100, 3'd3, 3'd5, 1'b1, 1'b1, 1'b0, 8, -1, 0, -1);
    for (int k = 0; k < 8; k++) wdat[k] = 64'hA000000000000000 + 64'(k);
    run_burst(0, 64'h100, 3'd3, 3'd5, 1'b1, 1'b1, 1'b0, 8, -1, 0, 3);
    check_eq("abort_beats_acked", 64'(n_res), 64'd3);
    rst = 1'b0;
    #1;
    check_quiet("abort_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_burst(0, 64'h100, 3'd3, 3'd5, 1'b0, 1'b1, 1'b0, 8, -1, 0, -1);
    for (int k = 0; k < 8; k++) begin
      if (k < 3) check_eq($sformatf("abort_new_%0d", k), r_q[k], 64'hA000000000000000 + 64'(k));
      else       check_eq($sformatf("abort_old_%0d", k), r_q[k], 64'h5000000000000000 + 64'(k));
    end

    // Locked channel 0 keeps the grant over a pending channel 1.
    gnt_log.delete();
    run_burst(0, 64'h100, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 1, -1, 0, -1);
    adri[PLEN +: PLEN] = 64'h108; size[3 +: 3] = 3'd3; btype[3 +: 3] = 3'd0; prot[3 +: 3] = 3'd1;
    we[1] = 1'b0; lock[1] = 1'b0; stb[1] = 1'b1;
    run_burst(0, 64'h110, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 1, -1, 0, -1);
    check_eq("lock_regrant_q", r_q[0], 64'hA000000000000002);
    check_eq("lock_ch1_quiet", 64'(other_nz), 64'd0);
    lock[0] = 1'b0;
    run_burst(1, 64'h108, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1, -1, 0, -1);
    check_eq("lock_release_q", r_q[0], 64'hA000000000000001);
    check_eq("lock_grant_count", 64'(gnt_log.size()), 64'd3);
    if (gnt_log.size() == 3) begin
      check_eq("lock_grant_order", 64'({gnt_log[0][1:0], gnt_log[1][1:0], gnt_log[2][1:0]}), 64'b00_00_01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
